palindrome_builder: RTL and testbench

//   Bit-serial generator of WIDTH-bit binary palindromes: the inverse of the palindrome checker.

---
 rtl/palindrome_builder.sv | 72 +++++++
 tb/tb_palindrome_builder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/palindrome_builder.sv
// palindrome_builder: bit-serial mirror of a HALF-bit seed into a WIDTH-bit palindrome
// Ports: clk, reset (sync, active-high); in_valid/in_ready/seed_in seed handshake;
//   out_valid/out_ready/out_data result handshake; busy while building;
//   check_ok (only with PAL_SELFCHECK_EN) flags that out_data is a true palindrome.
module palindrome_builder #(
  parameter int WIDTH = 32,
  localparam int HALF = WIDTH / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [HALF-1:0]  seed_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef PAL_SELFCHECK_EN
  ,
  output logic             check_ok
`endif
);
  localparam int CW = $clog2(HALF);
  typedef enum logic [1:0] {IDLE, BUILD, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [HALF-1:0] shift;
  logic [WIDTH-1:0] work, work_nxt, lo, hi;
  logic last;
  assign in_ready = state == IDLE;
  assign busy = state == BUILD;
  assign out_valid = state == DONE;
  always_comb begin
    lo = WIDTH'(1) << cnt;
    hi = {1'b1, {(WIDTH-1){1'b0}}} >> cnt;
    work_nxt = shift[0] ? (work | lo | hi) : (work & ~(lo | hi));
    last = cnt == CW'(HALF - 1);
    state_nxt = state == IDLE  ? (in_valid ? BUILD : IDLE) :
                state == BUILD ? (last ? DONE : BUILD) :
                state == DONE  ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
`ifdef PAL_SELFCHECK_EN
  logic pal_ok;
  always_comb begin
    pal_ok = 1'b1;
    for (int i = 0; i < HALF; i++) pal_ok = pal_ok & (work_nxt[i] ~^ work_nxt[WIDTH-1-i]);
  end
  always_ff @(posedge clk)
    if (reset) check_ok <= 1'b0;
    else if (state == BUILD && last) check_ok <= pal_ok;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      shift <= '0;
      work <= '0;
      out_data <= '0;
    end else if (state == IDLE && in_valid) begin
      shift <= seed_in;
      work <= '0;
      cnt <= '0;
    end else if (state == BUILD) begin
      shift <= shift >> 1;
      work <= work_nxt;
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) out_data <= work_nxt;
    end
  end
endmodule

// File: tb/tb_palindrome_builder.sv
// tb_palindrome_builder: directed self-checking bench for palindrome_builder
module tb_palindrome_builder;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] seed_in = '0;
  logic in_ready, out_valid, busy;
  logic [31:0] out_data;
  int n_assert = 0, n_fail = 0;
`ifdef PAL_SELFCHECK_EN
  logic check_ok;
`endif
  palindrome_builder #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .seed_in(seed_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
`ifdef PAL_SELFCHECK_EN
    , .check_ok(check_ok)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic build(input string tag, input logic [15:0] seed, input logic [31:0] exp);
    int n;
    logic ir_low;
    in_valid = 1'b1;
    seed_in = seed;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    ir_low = 1'b1;
    while (!out_valid && n < 40) begin
      if (in_ready) ir_low = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd16);
    chk({tag, "_in_ready_low"}, 64'(ir_low), 64'd1);
    chk({tag, "_data"}, 64'(out_data), 64'(exp));
`ifdef PAL_SELFCHECK_EN
    chk({tag, "_check_ok"}, 64'(check_ok), 64'd1);
`endif
  endtask
  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_rel_in_ready"}, 64'(in_ready), 64'd1);
  endtask
  initial begin
    int n;
    tick();
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    chk("idle_out_ready_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_ready_valid", 64'(out_valid), 64'd0);
    build("t1", 16'h0001, 32'h8000_0001);
    release_out("t1");
    build("t2", 16'hABCD, 32'hB3D5_ABCD);
    release_out("t2");
    build("t3a", 16'h0000, 32'h0000_0000);
    release_out("t3a");
    build("t3b", 16'hFFFF, 32'hFFFF_FFFF);
    release_out("t3b");
    build("t4", 16'h00F0, 32'h0F00_00F0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_data", 64'(out_data), 64'h0F00_00F0);
      chk("t4_hold_in_ready", 64'(in_ready), 64'd0);
    end
    release_out("t4");
    chk("t4_data_kept", 64'(out_data), 64'h0F00_00F0);
    in_valid = 1'b1;
    seed_in = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t5_midbuild_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_out_data", 64'(out_data), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("t5_no_partial", 64'(out_valid), 64'd0);
    chk("t5_data_zero", 64'(out_data), 64'd0);
    in_valid = 1'b1;
    seed_in = 16'h0001;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    in_valid = 1'b1;
    seed_in = 16'h1234;
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    n = 5;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t6_latency", 64'(n), 64'd16);
    chk("t6_data", 64'(out_data), 64'h8000_0001);
    release_out("t6");
    in_valid = 1'b1;
    seed_in = 16'h0005;
    out_ready = 1'b1;
    tick();
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("t7_period", 64'(n), 64'd17);
    chk("t7_data", 64'(out_data), 64'hA000_0005);
    tick();
    chk("t7_reaccept", 64'(busy), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
